// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one UART transmitter among NUM_REQ clients.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*8-1:0]   data_i,
    input  logic [NUM_REQ-1:0]     par_en_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_par_en_o,
    input  logic                   tx_busy_i,
    input  logic                   tx_done_i,
    output logic [ID_W-1:0]        owner_o,
    output logic                   busy_o
);

    localparam int                 c_TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]    c_LAST_IDX = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        w_rr_ptr_nxt;
    logic [ID_W-1:0]        r_owner;
    logic [ID_W-1:0]        w_owner_nxt;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [NUM_REQ-1:0]     r_ack;
    logic [NUM_REQ-1:0]     w_ack_nxt;
    logic [NUM_REQ-1:0]     r_done;
    logic [NUM_REQ-1:0]     w_done_nxt;
    logic [NUM_REQ-1:0]     r_err;
    logic [NUM_REQ-1:0]     w_err_nxt;
    logic                   r_tx_valid;
    logic                   w_tx_valid_nxt;
    logic [7:0]             r_tx_data;
    logic [7:0]             w_tx_data_nxt;
    logic                   r_tx_par_en;
    logic                   w_tx_par_en_nxt;

    logic                   w_win_found;
    logic [ID_W-1:0]        w_win_idx;
    logic [7:0]             w_win_data;
    logic                   w_win_par;
    int                     w_best_dist;
    int                     w_dist;
    logic [ID_W-1:0]        w_rr_after_owner;
    logic                   w_timeout;

    // Winner is the requester with the smallest rotational distance from rr_ptr.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_data  = 8'h00;
        w_win_par   = 1'b0;
        w_best_dist = NUM_REQ;
        w_dist      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k - int'(r_rr_ptr) + NUM_REQ) % NUM_REQ;
            if (req_i[k] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_found = 1'b1;
                w_win_idx   = ID_W'(k);
                w_win_data  = data_i[k*8 +: 8];
                w_win_par   = par_en_i[k];
            end
        end
    end

    assign w_rr_after_owner = (r_owner == c_LAST_IDX) ? '0 : r_owner + ID_W'(1);
    assign w_timeout        = (r_timer == c_TIMER_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_timer_nxt     = r_timer;
        w_ack_nxt       = '0;
        w_done_nxt      = '0;
        w_err_nxt       = '0;
        w_tx_valid_nxt  = r_tx_valid;
        w_tx_data_nxt   = r_tx_data;
        w_tx_par_en_nxt = r_tx_par_en;

        case (r_state)
            S_IDLE: begin
                w_tx_valid_nxt = 1'b0;
                if (w_win_found) begin
                    w_owner_nxt     = w_win_idx;
                    w_tx_data_nxt   = w_win_data;
                    w_tx_par_en_nxt = w_win_par;
                    w_ack_nxt       = c_ONE << w_win_idx;
                    w_tx_valid_nxt  = 1'b1;
                    w_timer_nxt     = '0;
                    w_state_nxt     = S_LAUNCH;
                end
            end
            S_LAUNCH, S_WAIT_DONE: begin
                w_timer_nxt = r_timer + c_TIMER_W'(1);
                if (r_state == S_WAIT_DONE) begin
                    w_tx_valid_nxt = 1'b0;
                end
                // Completion beats timeout; timeout beats the busy handshake.
                if (tx_done_i) begin
                    w_done_nxt     = c_ONE << r_owner;
                    w_tx_valid_nxt = 1'b0;
                    w_rr_ptr_nxt   = w_rr_after_owner;
                    w_state_nxt    = S_IDLE;
                end else if (w_timeout) begin
                    w_err_nxt      = c_ONE << r_owner;
                    w_tx_valid_nxt = 1'b0;
                    w_rr_ptr_nxt   = w_rr_after_owner;
                    w_state_nxt    = S_IDLE;
                end else if ((r_state == S_LAUNCH) && tx_busy_i) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = S_WAIT_DONE;
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_timer     <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_par_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_timer     <= w_timer_nxt;
            r_ack       <= w_ack_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_par_en <= w_tx_par_en_nxt;
        end
    end

    assign ack_o       = r_ack;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign tx_valid_o  = r_tx_valid;
    assign tx_data_o   = r_tx_data;
    assign tx_par_en_o = r_tx_par_en;
    assign owner_o     = r_owner;
    assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire
